// File: rtl/spi_cs_scheduler_if.sv
// SPI lane-0 pin bundle: SCK, four active-low chip selects, MOSI/OE, MISO.
// master drives SCK/CS/SDO/OEN and samples SDI; slave is the mirror.
interface spi_cs_scheduler_if;
  logic spi_clk_o;
  logic spi_csn0_o;
  logic spi_csn1_o;
  logic spi_csn2_o;
  logic spi_csn3_o;
  logic spi_oen0_o;
  logic spi_sdo0_o;
  logic spi_sdi0_i;

  modport master (
    output spi_clk_o,
    output spi_csn0_o,
    output spi_csn1_o,
    output spi_csn2_o,
    output spi_csn3_o,
    output spi_oen0_o,
    output spi_sdo0_o,
    input  spi_sdi0_i
  );

  modport slave (
    input  spi_clk_o,
    input  spi_csn0_o,
    input  spi_csn1_o,
    input  spi_csn2_o,
    input  spi_csn3_o,
    input  spi_oen0_o,
    input  spi_sdo0_o,
    output spi_sdi0_i
  );
endinterface

// File: rtl/spi_cs_scheduler.sv
// Round-robin SPI CS scheduler + mode-0 byte engine sharing lane 0.
// Ports: sys_clk_i/rstn_i (sync, active-low); req_i/len_i/gnt_o/busy_o
// arbitration; tx_data_i/tx_valid_i/tx_ready_o byte input;
// rx_data_o/rx_valid_o received byte; done_o frame end; spi (master
// modport) carries SCK, csn0..3, oen0, sdo0, sdi0.
// Optional macro SPI_CS_ABORT_EN adds abort_i / aborted_o.
module spi_cs_scheduler #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] len_i,
  output logic [3:0]  gnt_o,
  output logic        busy_o,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        done_o,
`ifdef SPI_CS_ABORT_EN
  input  logic        abort_i,
  output logic        aborted_o,
`endif
  spi_cs_scheduler_if.master spi
);

  localparam int TW = 16;
  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [3:0]    r_gnt;
  logic [3:0]    r_csn;
  logic          r_oen;
  logic          r_sck;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_tx_ready;
  logic          r_done;
  logic          r_abort;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [2:0]    r_bit;
  logic [TW-1:0] r_timer;
`ifdef SPI_CS_ABORT_EN
  logic          r_aborted;
`endif

  logic       w_hit;
  logic [1:0] w_pick;
  logic [7:0] w_len;
  logic       w_abort;

`ifdef SPI_CS_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // first requester at or above the pointer, wrapping mod 4
  always_comb begin
    logic [1:0] v_idx;
    w_hit  = 1'b0;
    w_pick = r_ptr;
    v_idx  = r_ptr;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_hit && req_i[v_idx]) begin
        w_hit  = 1'b1;
        w_pick = v_idx;
      end
    end
  end

  assign w_len = len_i[{w_pick, 3'b000} +: 8];

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_gnt      <= 4'h0;
      r_csn      <= 4'hF;
      r_oen      <= 1'b1;
      r_sck      <= 1'b0;
      r_shift    <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_len      <= 8'h00;
      r_cnt      <= 8'h00;
      r_bit      <= 3'd0;
      r_timer    <= '0;
`ifdef SPI_CS_ABORT_EN
      r_aborted  <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
`ifdef SPI_CS_ABORT_EN
      r_aborted  <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt   <= 4'b0001 << w_pick;
            r_csn   <= ~(4'b0001 << w_pick);
            r_oen   <= 1'b0;
            r_len   <= w_len;
            r_cnt   <= 8'h00;
            r_ptr   <= w_pick + 2'd1;
            r_timer <= '0;
            r_abort <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_abort) begin
            r_abort <= 1'b1;
            r_timer <= '0;
            r_state <= S_HOLD;
          end else if (r_timer == SETUP_LAST) begin
            r_timer    <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_LOAD: begin
          if (w_abort) begin
            r_abort    <= 1'b1;
            r_tx_ready <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_HOLD;
          end else if (tx_valid_i && r_tx_ready) begin
            r_shift    <= tx_data_i;
            r_tx_ready <= 1'b0;
            r_timer    <= '0;
            r_bit      <= 3'd0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // abort is remembered and honoured only at the byte boundary
          if (w_abort) r_abort <= 1'b1;
          if (r_timer != DIV_LAST) begin
            r_timer <= r_timer + 16'd1;
          end else begin
            r_timer <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[6:0], spi.spi_sdi0_i};
            end else begin
              r_sck   <= 1'b0;
              r_shift <= {r_shift[6:0], 1'b0};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_rx_data  <= r_rx;
                r_rx_valid <= 1'b1;
                if (r_cnt == r_len || r_abort || w_abort) begin
                  r_state <= S_HOLD;
                end else begin
                  r_cnt      <= r_cnt + 8'd1;
                  r_tx_ready <= 1'b1;
                  r_state    <= S_LOAD;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (r_timer == HOLD_LAST) begin
            r_timer   <= '0;
            r_csn     <= 4'hF;
            r_oen     <= 1'b1;
            r_shift   <= 8'h00;
            r_gnt     <= 4'h0;
            r_done    <= 1'b1;
`ifdef SPI_CS_ABORT_EN
            r_aborted <= r_abort;
`endif
            r_state   <= S_GAP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign busy_o     = |r_gnt;
  assign tx_ready_o = r_tx_ready;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign done_o     = r_done;
`ifdef SPI_CS_ABORT_EN
  assign aborted_o  = r_aborted;
`endif

  assign spi.spi_clk_o  = r_sck;
  assign spi.spi_csn0_o = r_csn[0];
  assign spi.spi_csn1_o = r_csn[1];
  assign spi.spi_csn2_o = r_csn[2];
  assign spi.spi_csn3_o = r_csn[3];
  assign spi.spi_oen0_o = r_oen;
  assign spi.spi_sdo0_o = r_shift[7];

endmodule
